// File: rtl/frame_buffer_pkg.sv
// Shared definitions for the dual-bank frame buffer.
//   - wr_state_e        : write-side FSM state encoding
//   - DEFAULT_SYNC_BYTE : default start-of-frame marker
//   - win_off / in_span : centred-window offset and range helpers
package frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

  // Offset that centres an image span inside a screen span.
  function automatic int win_off(input int screen, input int img);
    return (screen - img) / 2;
  endfunction

  // True when off <= pos < off+len.
  function automatic logic in_span(input int pos, input int off, input int len);
    return (pos >= off) && (pos < off + len);
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both frame banks.
//   clk   : clock
//   we    : write enable; waddr/wdata written at the edge
//   raddr : read address; rdata is registered (one-cycle read latency)
module fb_bank_ram #(
  parameter int WORDS  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [WORDS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dual_bank_frame_buffer.sv
// Double-buffered frame store. A sync byte opens a frame that is written into
// the back bank; once complete, the banks swap at the next screen origin, so a
// partially loaded image is never shown. The image is displayed centred in the
// raster with BG_VALUE fill around it.
//   pixel_clk, rst        : clock, async active-high reset
//   wr_valid, wr_data     : incoming byte stream (sync byte + pixels)
//   h_pos, v_pos          : raster position sampled each cycle
//   data_out, in_window   : display pixel, valid 2 edges after the sample
//   frame_ready           : a frame has been swapped in since reset
//   swap_pulse, drop_pulse: one-cycle event pulses
module dual_bank_frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int               IMG_W     = 534,
  parameter int               IMG_H     = 400,
  parameter int               PIX_W     = 8,
  parameter int               SCREEN_W  = 640,
  parameter int               SCREEN_H  = 480,
  parameter logic [PIX_W-1:0] SYNC_BYTE = PIX_W'(DEFAULT_SYNC_BYTE),
  parameter logic [PIX_W-1:0] BG_VALUE  = '0
) (
  input  logic                        pixel_clk,
  input  logic                        rst,
  input  logic                        wr_valid,
  input  logic [PIX_W-1:0]            wr_data,
  input  logic [$clog2(SCREEN_W)-1:0] h_pos,
  input  logic [$clog2(SCREEN_H)-1:0] v_pos,
  output logic [PIX_W-1:0]            data_out,
  output logic                        in_window,
  output logic                        frame_ready,
  output logic                        swap_pulse,
  output logic                        drop_pulse
);

  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ADDR_W = $clog2(2 * DEPTH);
  localparam int X0     = win_off(SCREEN_W, IMG_W);
  localparam int Y0     = win_off(SCREEN_H, IMG_H);

  wr_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              disp_bank_q, disp_bank_d;
  logic              frame_ready_q, frame_ready_d;
  logic              swap_pulse_q, swap_pulse_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  // [0]: stage holding rd_addr, [1]: stage holding RAM data
  logic [1:0]        win_pipe_q, win_pipe_d;
  logic [1:0]        show_pipe_q, show_pipe_d;
  logic              in_window_q, in_window_d;
  logic [PIX_W-1:0]  data_out_q, data_out_d;

  logic              origin, in_win, we;
  logic [PTR_W-1:0]  eff_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  rdata;

  always_comb begin
    origin        = (h_pos == '0) && (v_pos == '0);
    in_win        = in_span(int'(h_pos), X0, IMG_W) && in_span(int'(v_pos), Y0, IMG_H);
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    disp_bank_d   = disp_bank_q;
    frame_ready_d = frame_ready_q;
    swap_pulse_d  = 1'b0;
    drop_pulse_d  = 1'b0;
    we            = 1'b0;

    case (state_q)
      ST_IDLE: if (wr_valid && wr_data == SYNC_BYTE) begin
        state_d  = ST_LOAD;
        wr_ptr_d = '0;
      end
      ST_LOAD: if (wr_valid) begin
        we = 1'b1;
        if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d  = ST_DONE;
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      ST_DONE: begin
        drop_pulse_d = wr_valid;
        if (origin) begin
          disp_bank_d   = ~disp_bank_q;
          swap_pulse_d  = 1'b1;
          frame_ready_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write bank is the non-displayed bank as of this cycle.
    wr_addr = (disp_bank_q ? '0 : ADDR_W'(DEPTH)) + ADDR_W'(wr_ptr_q);

    // Origin restarts the read scan; address uses the post-swap bank so the
    // first frame after a swap comes from the new bank.
    eff_ptr = origin ? '0 : rd_ptr_q;
    if (in_win) rd_ptr_d = (eff_ptr == PTR_W'(DEPTH - 1)) ? '0 : eff_ptr + 1'b1;
    else        rd_ptr_d = eff_ptr;
    rd_addr_d = (disp_bank_d ? ADDR_W'(DEPTH) : '0) + ADDR_W'(eff_ptr);

    win_pipe_d  = {win_pipe_q[0], in_win};
    show_pipe_d = {show_pipe_q[0], in_win && frame_ready_d};
    in_window_d = win_pipe_q[1];
    data_out_d  = show_pipe_q[1] ? rdata : BG_VALUE;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      disp_bank_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      swap_pulse_q  <= 1'b0;
      drop_pulse_q  <= 1'b0;
      rd_addr_q     <= '0;
      win_pipe_q    <= '0;
      show_pipe_q   <= '0;
      in_window_q   <= 1'b0;
      data_out_q    <= BG_VALUE;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      disp_bank_q   <= disp_bank_d;
      frame_ready_q <= frame_ready_d;
      swap_pulse_q  <= swap_pulse_d;
      drop_pulse_q  <= drop_pulse_d;
      rd_addr_q     <= rd_addr_d;
      win_pipe_q    <= win_pipe_d;
      show_pipe_q   <= show_pipe_d;
      in_window_q   <= in_window_d;
      data_out_q    <= data_out_d;
    end
  end

  fb_bank_ram #(
    .WORDS (2 * DEPTH),
    .WIDTH (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (pixel_clk),
    .we   (we),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr_q),
    .rdata(rdata)
  );

  assign data_out    = data_out_q;
  assign in_window   = in_window_q;
  assign frame_ready = frame_ready_q;
  assign swap_pulse  = swap_pulse_q;
  assign drop_pulse  = drop_pulse_q;

endmodule

// File: tb/tb_dual_bank_frame_buffer.sv
// Bench for dual_bank_frame_buffer with a 4x2 image in an 8x4 raster.
// The model tracks complete frames as pixel images and predicts each output
// from the raster coordinates; a negedge process compares every cycle.
module tb_dual_bank_frame_buffer;
  localparam int IW = 4, IH = 2, SW = 8, SH = 4, DEPTH = IW * IH;
  localparam int X0 = 2, Y0 = 1;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic [2:0] h_pos = '0;
  logic [1:0] v_pos = '0;
  logic [7:0] data_out;
  logic       in_window, frame_ready, swap_pulse, drop_pulse;

  dual_bank_frame_buffer #(
    .IMG_W(IW), .IMG_H(IH), .PIX_W(8), .SCREEN_W(SW), .SCREEN_H(SH),
    .SYNC_BYTE(8'hAA), .BG_VALUE(8'h00)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .h_pos(h_pos), .v_pos(v_pos), .data_out(data_out), .in_window(in_window),
    .frame_ready(frame_ready), .swap_pulse(swap_pulse), .drop_pulse(drop_pulse)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests = 0, n_fail = 0;
  int n_swap = 0, n_drop = 0;
  int win_obs[$];
  int sched[int];
  bit chk_en = 0;

  // model: 0 idle, 1 collecting pixels, 2 complete frame waiting for origin
  int m_state, m_cnt;
  int ld_img[DEPTH];
  int disp_img[DEPTH];
  bit m_fr;
  int e_dat[3];
  bit e_win[3];
  bit e_swap, e_drop, e_fr;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_fr = 0;
    e_swap = 0; e_drop = 0; e_fr = 0;
    for (int i = 0; i < 3; i++) begin e_dat[i] = 0; e_win[i] = 0; end
  endtask

  always @(negedge pixel_clk) begin
    if (chk_en && !rst) begin
      check("data_out", data_out, e_dat[2]);
      check("in_window", in_window, e_win[2]);
      check("frame_ready", frame_ready, e_fr);
      check("swap_pulse", swap_pulse, e_swap);
      check("drop_pulse", drop_pulse, e_drop);
      if (swap_pulse) n_swap++;
      if (drop_pulse) n_drop++;
      if (in_window) win_obs.push_back(int'(data_out));
    end
  end

  task automatic step(input int h, input int v, input bit vld, input int d);
    bit sw, dr, win;
    int dat;
    h_pos = 3'(h); v_pos = 2'(v); wr_valid = vld; wr_data = 8'(d);
    sw = 0; dr = 0;
    if (m_state == 2) begin
      dr = vld;
      if (h == 0 && v == 0) begin
        sw = 1; m_fr = 1; m_state = 0;
        disp_img = ld_img;
      end
    end else if (m_state == 0) begin
      if (vld && d == 8'hAA) begin m_state = 1; m_cnt = 0; end
    end else if (vld) begin
      ld_img[m_cnt] = d;
      m_cnt++;
      if (m_cnt == DEPTH) m_state = 2;
    end
    win = (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
    dat = (win && m_fr) ? disp_img[(v - Y0) * IW + (h - X0)] : 0;
    @(posedge pixel_clk); #1;
    e_dat[2] = e_dat[1]; e_dat[1] = e_dat[0]; e_dat[0] = dat;
    e_win[2] = e_win[1]; e_win[1] = e_win[0]; e_win[0] = win;
    e_swap = sw; e_drop = dr; e_fr = m_fr;
  endtask

  // Runs the first n cycles of a raster, injecting scheduled bytes.
  task automatic raster_n(input int n);
    win_obs.delete();
    for (int c = 0; c < n; c++) begin
      if (sched.exists(c)) step(c % SW, c / SW, 1'b1, sched[c]);
      else                 step(c % SW, c / SW, 1'b0, 0);
    end
    sched.delete();
  endtask

  task automatic raster();
    raster_n(SW * SH);
  endtask

  task automatic check_win(input string name, input int exp[DEPTH]);
    check({name, "_count"}, win_obs.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < win_obs.size(); i++)
      check(name, win_obs[i], exp[i]);
  endtask

  task automatic load_frame(input int start, input int first);
    sched[start] = 8'hAA;
    for (int i = 0; i < DEPTH; i++) sched[start + 1 + i] = first + i;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_data_out", data_out, 0);
    check("rst_in_window", in_window, 0);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_swap", swap_pulse, 0);
    check("rst_drop", drop_pulse, 0);
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    chk_en = 1;

    // Empty raster: background only, window flag for 8 positions.
    raster();
    check_win("t1_bg", '{0, 0, 0, 0, 0, 0, 0, 0});
    check("t1_frame_ready", frame_ready, 0);

    // 0x11 ignored, then AA + 1..8.
    sched[1] = 8'h11;
    load_frame(2, 1);
    raster();
    check("t2_no_swap_yet", n_swap, 0);
    raster();
    check("t2_swaps", n_swap, 1);
    check_win("t2_frame", '{1, 2, 3, 4, 5, 6, 7, 8});

    // Load 9..16 mid-raster; current raster still shows 1..8.
    load_frame(10, 9);
    raster();
    check_win("t3_old", '{1, 2, 3, 4, 5, 6, 7, 8});
    raster();
    check("t3_swaps", n_swap, 2);
    check_win("t3_new", '{9, 10, 11, 12, 13, 14, 15, 16});

    // Complete frame 17..24, then 3 bytes in DONE and one at the swap origin.
    load_frame(1, 17);
    sched[20] = 8'hEE; sched[21] = 8'hEE; sched[22] = 8'hEE;
    raster();
    check("t4_drops", n_drop, 3);
    check_win("t4_old", '{9, 10, 11, 12, 13, 14, 15, 16});
    sched[0] = 8'hEE;
    raster();
    check("t4_drops_swap", n_drop, 4);
    check("t4_swaps", n_swap, 3);
    check_win("t4_new", '{17, 18, 19, 20, 21, 22, 23, 24});

    // Reset after 5 pixels of a load, while the window is being output.
    sched[1] = 8'hAA;
    for (int i = 0; i < 5; i++) sched[2 + i] = 31 + i;
    raster_n(20);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_rst_data_out", data_out, 0);
    check("t5_rst_in_window", in_window, 0);
    check("t5_rst_frame_ready", frame_ready, 0);
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    raster();
    check_win("t5_blank", '{0, 0, 0, 0, 0, 0, 0, 0});
    check("t5_frame_ready", frame_ready, 0);
    load_frame(1, 41);
    raster();
    raster();
    check("t5_frame_ready_after", frame_ready, 1);
    check_win("t5_new", '{41, 42, 43, 44, 45, 46, 47, 48});

    // Second sync byte is stored as pixel 0.
    sched[1] = 8'hAA; sched[2] = 8'hAA;
    for (int i = 0; i < 7; i++) sched[3 + i] = 2 + i;
    raster();
    raster();
    check_win("t6_aa_pixel", '{170, 2, 3, 4, 5, 6, 7, 8});
    check("final_swaps", n_swap, 5);
    check("final_drops", n_drop, 4);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_bank_frame_buffer.md
# dual_bank_frame_buffer

Parametrised, double-buffered frame store for the HDMI edge-detection path. It accepts a byte-stream image (one pixel per `wr_valid`), framed by a sync byte, into a back bank. At the first screen origin after a frame completes, the back bank becomes the display bank, so the video timing generator never shows a partially loaded image. Output is a centred window of `IMG_W`×`IMG_H` pixels inside the `SCREEN_W`×`SCREEN_H` raster, with background fill outside.

## Interface
- `IMG_W`, 534: image width in pixels.
- `IMG_H`, 400: image height in pixels.
- `PIX_W`, 8: pixel width in bits.
- `SCREEN_W`, 640: raster width. Must be ≥ `IMG_W`.
- `SCREEN_H`, 480: raster height. Must be ≥ `IMG_H`.
- `SYNC_BYTE`, 8'hAA (`PIX_W` bits): start-of-frame marker.
- `BG_VALUE`, 0 (`PIX_W` bits): fill value outside the window or when no frame exists.
- `pixel_clk`  in  1  sole clock. Both the write and read sides run on it.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  `wr_data` is valid this cycle.
- `wr_data`  in  `PIX_W`  incoming pixel or sync byte.
- `h_pos`  in  $clog2(SCREEN_W)  current raster column.
- `v_pos`  in  $clog2(SCREEN_H)  current raster row.
- `data_out`  out  `PIX_W`  display pixel.
- `in_window`  out  1  `data_out` lies inside the image window. Aligned with `data_out`.
- `frame_ready`  out  1  a complete frame has been swapped to display at least once since reset.
- `swap_pulse`  out  1  one-cycle pulse on a bank swap.
- `drop_pulse`  out  1  one-cycle pulse when a `wr_valid` byte is discarded while in the DONE state.

## Operation
**Constants**
- DEPTH = IMG_W*IMG_H.
- X0 = (SCREEN_W−IMG_W)/2 and Y0 = (SCREEN_H−IMG_H)/2, using integer division.
- A position is in the window when X0 ≤ h_pos < X0+IMG_W and Y0 ≤ v_pos < Y0+IMG_H.

**Memory**
- 2·DEPTH words, split into bank 0 and bank 1.
- `disp_bank` selects the display bank. The write bank is always `~disp_bank`.

**Write FSM**
- IDLE:
  - `wr_valid && wr_data==SYNC_BYTE` → LOAD, with wr_ptr=0.
  - Any other byte is ignored silently.
- LOAD:
  - Each `wr_valid` writes `mem[wbank*DEPTH+wr_ptr]` and increments wr_ptr.
  - SYNC_BYTE values are stored as ordinary pixels.
  - The write at wr_ptr==DEPTH−1 → DONE, with wr_ptr=0.
- DONE:
  - Incoming `wr_valid` bytes are discarded, and `drop_pulse` fires for each.
  - On a cycle with h_pos==0 && v_pos==0, a swap occurs: `disp_bank` toggles, `swap_pulse`=1, `frame_ready`=1, and the state returns to IDLE.
  - A `wr_valid` in the swap cycle is dropped and raises `drop_pulse`.

**Read side**
- eff_ptr = (h_pos==0 && v_pos==0) ? 0 : rd_ptr.
- The read address is `disp_bank_next*DEPTH + eff_ptr`. `disp_bank_next` is the post-swap bank when a swap occurs in that cycle.
- rd_ptr ← eff_ptr+1 when in the window, otherwise eff_ptr.
- rd_ptr wraps from DEPTH−1 to 0.

**Output**
- If the delayed in-window flag is set and `frame_ready` was set at the time of read: `data_out` = memory word.
- Otherwise: `data_out` = BG_VALUE.

## Timing
**Reset** (immediate, asynchronous):
- `data_out`=BG_VALUE; `in_window`, `frame_ready`, `swap_pulse` and `drop_pulse` = 0.
- FSM=IDLE, wr_ptr=rd_ptr=0, disp_bank=0.

**Write path**
- Write latency is one cycle.
- A swap is decided combinationally from the h_pos/v_pos sample and the state, and registered at that edge.

**Read path**
- Latency is 2 cycles: h_pos/v_pos sampled at edge t → address registered at t → synchronous RAM read at t+1 → `data_out`/`in_window` valid after edge t+2.
- The pixel read at the origin cycle of a swap comes from the new bank.

**Reset mid-LOAD**
- The partial frame is abandoned. `frame_ready`=0 until the next complete frame is swapped in.
- The previously displayed bank contents are not shown.

**Edge cases**
- X0=Y0=0: origin (0,0) is in the window and must read address 0 of the display bank.
- IMG_W=SCREEN_W is allowed and has no horizontal border.

## Structure
- Shared package `frame_buffer_pkg`:
  - write-FSM state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2);
  - default SYNC_BYTE;
  - window offset helper functions.
- Sub-module `fb_bank_ram`:
  - simple dual-port, `ram_style="block"`;
  - one write port and one registered read port;
  - depth 2·DEPTH, width PIX_W.
- The top level holds the FSM, pointers, swap logic and output pipeline.

## Test plan
All scenarios use IMG 4×2 and SCREEN 8×4, giving X0=2, Y0=1.

- Reset then scan a full raster → `data_out`=0 and `in_window` is 1 exactly for (2..5, 1..2), delayed by 2 cycles. `frame_ready`=0.
- Send 0x11, then AA, then 1..8 → 0x11 is ignored. FSM reaches DONE after 8 writes. The next (0,0) gives `swap_pulse`=1. At (2,1) `data_out`=1 two cycles later; (5,2) gives 8.
- After a displayed frame, send AA, 9..16 mid-raster → the current raster still shows 1..8. The following raster shows 9..16 and `disp_bank` has toggled.
- With FSM in DONE, send 3 bytes before the origin → 3 `drop_pulse`s, no memory change. A byte coincident with the swap cycle is also dropped.
- Assert `rst` during LOAD after 5 bytes → outputs clear immediately and `frame_ready`=0. A new AA+8 bytes is displayed correctly after the next origin.
- Send AA, AA, 2..8 → the second AA is stored as pixel 0, so (2,1) outputs 0xAA.
